irq_priority_ctrl: RTL and testbench

Parametrised, clocked interrupt controller for the CPU interrupt path. It edge-detects `NUM_IRQ` request lines and latches them as pending. It selects the highest-priority unmasked pending request, where the lowest index wins. It then issues a fixed-width `IRQ` pulse with a stable `irq_id`, and holds that service until the CPU acknowledges. The block registers the priority encode, replaces delay-based pulse timing with a cycle counter, and adds masking, pending latches and an acknowledge handshake.

---
 rtl/irq_priority_ctrl.sv | 117 +++++++++++
 tb/tb_irq_priority_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: edge-latched, masked, fixed-priority interrupt
// controller with a counted IRQ pulse/gap and an ack handshake.
module irq_priority_ctrl #(
  parameter int NUM_IRQ         = 4,
  parameter int ID_W            = $clog2(NUM_IRQ),
  parameter int IRQ_PULSE_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] interrupts,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               ack,
  output logic [ID_W-1:0]    irq_id,
  output logic               IRQ,
  output logic               busy,
  output logic [NUM_IRQ-1:0] pending
);

  localparam int CW = $clog2(IRQ_PULSE_WIDTH + 1);
  localparam logic [CW-1:0] RELOAD = CW'(IRQ_PULSE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    WAIT_ACK
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [ID_W-1:0]   id_n;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] clr;
  logic [ID_W-1:0]   win;
  logic              any;

  assign rise = interrupts & ~prev;
  assign cand = pending & mask;
  assign any  = |cand;
  assign IRQ  = (state == PULSE);
  assign busy = (state != IDLE);

  // Lowest set index of the candidate vector wins.
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) win = ID_W'(i);
    end
  end

  // One-hot clear for the line whose ack is accepted this cycle.
  always_comb begin
    clr = '0;
    if (state == WAIT_ACK && ack) clr[irq_id] = 1'b1;
  end

  // Edge history and pending latches; a new rise beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      pending <= '0;
    end else begin
      prev    <= interrupts;
      pending <= (pending & ~clr) | rise;
    end
  end

  // Service FSM next-state, pulse counter and id latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    id_n    = irq_id;
    unique case (state)
      IDLE: begin
        if (any) begin
          id_n    = win;
          cnt_n   = RELOAD;
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          cnt_n   = RELOAD;
          state_n = GAP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_n = WAIT_ACK;
        else cnt_n = cnt - CW'(1);
      end
      WAIT_ACK: begin
        if (ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Service FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      irq_id <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      irq_id <= id_n;
    end
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb_irq_priority_ctrl: directed plan scenarios plus random traffic,
// checked every cycle against a cycle-count service model.
module tb_irq_priority_ctrl;

  localparam int N  = 4;
  localparam int PW = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] interrupts = '0;
  logic [N-1:0] mask = '1;
  logic         ack = 1'b0;
  logic [1:0]   irq_id;
  logic         IRQ;
  logic         busy;
  logic [N-1:0] pending;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit [N-1:0] m_prev;
  bit [N-1:0] m_pend;
  bit         m_active;
  int         m_t;
  int         m_id;

  irq_priority_ctrl #(
    .NUM_IRQ(N),
    .IRQ_PULSE_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .interrupts(interrupts),
    .mask(mask),
    .ack(ack),
    .irq_id(irq_id),
    .IRQ(IRQ),
    .busy(busy),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_prev = '0;
    m_pend = '0;
    m_active = 1'b0;
    m_t = 0;
    m_id = 0;
  endtask

  // One rising edge of the behavioural model.
  task automatic m_step();
    bit [N-1:0] rise;
    bit [N-1:0] cand;
    bit [N-1:0] clrv;
    rise = interrupts & ~m_prev;
    cand = m_pend & mask;
    clrv = '0;
    if (m_active) begin
      if (m_t >= 2 * PW && ack) begin
        clrv[m_id] = 1'b1;
        m_active = 1'b0;
      end else if (m_t < 2 * PW) begin
        m_t++;
      end
    end else if (cand != 0) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) begin
          m_id = i;
          break;
        end
      end
      m_active = 1'b1;
      m_t = 0;
    end
    m_pend = (m_pend & ~clrv) | rise;
    m_prev = interrupts;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".irq"}, int'(IRQ), int'(m_active && m_t < PW));
    chk({tag, ".busy"}, int'(busy), int'(m_active));
    chk({tag, ".id"}, int'(irq_id), m_id);
    chk({tag, ".pend"}, int'(pending), int'(m_pend));
  endtask

  task automatic cycle(input logic [N-1:0] i_v, input logic [N-1:0] m_v,
                       input logic a_v);
    interrupts = i_v;
    mask = m_v;
    ack = a_v;
    @(posedge clk);
    m_step();
    #1;
    check_all("cyc");
  endtask

  function automatic bit m_waiting();
    return m_active && m_t >= 2 * PW;
  endfunction

  // Idle-ack cycles until the model reaches the ack window, bounded.
  task automatic run_to_wait(input logic [N-1:0] i_v, input logic [N-1:0] m_v);
    int n = 0;
    while (!m_waiting() && n < 20) begin
      cycle(i_v, m_v, 1'b0);
      n++;
    end
    if (!m_waiting()) chk("wait_timeout", 0, 1);
  endtask

  // Asynchronous reset asserted between clock edges, released on a negedge.
  task automatic async_reset(input int hold);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    check_all("rst_now");
    chk("rst_irq", int'(IRQ), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_all("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    m_reset();
    #1;
    check_all("reset");
    chk("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    check_all("reset2");
    @(negedge clk);
    rst = 1'b0;

    // single request on line 2
    cycle(4'b0000, 4'b1111, 1'b0);
    cycle(4'b0100, 4'b1111, 1'b0);
    chk("single_pend", int'(pending), 4);
    chk("single_noirq", int'(IRQ), 0);
    cycle(4'b0100, 4'b1111, 1'b0);
    chk("single_irq1", int'(IRQ), 1);
    chk("single_id", int'(irq_id), 2);
    cycle(4'b0100, 4'b1111, 1'b0);
    chk("single_irq2", int'(IRQ), 1);
    cycle(4'b0100, 4'b1111, 1'b0);
    chk("single_gap1", int'(IRQ), 0);
    chk("single_busy", int'(busy), 1);
    run_to_wait(4'b0100, 4'b1111);
    cycle(4'b0100, 4'b1111, 1'b1);
    chk("single_ack_pend", int'(pending), 0);
    chk("single_ack_busy", int'(busy), 0);

    // priority: lines 1 and 3 rise together
    cycle(4'b0000, 4'b1111, 1'b0);
    cycle(4'b1010, 4'b1111, 1'b0);
    cycle(4'b1010, 4'b1111, 1'b0);
    chk("prio_first", int'(irq_id), 1);
    run_to_wait(4'b1010, 4'b1111);
    cycle(4'b1010, 4'b1111, 1'b1);
    chk("prio_idle", int'(busy), 0);
    cycle(4'b1010, 4'b1111, 1'b0);
    chk("prio_second", int'(irq_id), 3);
    chk("prio_second_irq", int'(IRQ), 1);
    run_to_wait(4'b1010, 4'b1111);
    cycle(4'b0000, 4'b1111, 1'b1);

    // masking line 0
    cycle(4'b0001, 4'b1110, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'b0001, 4'b1110, 1'b0);
    chk("mask_pend", int'(pending), 1);
    chk("mask_noirq", int'(IRQ), 0);
    cycle(4'b0001, 4'b1111, 1'b0);
    cycle(4'b0001, 4'b1111, 1'b0);
    chk("unmask_irq", int'(IRQ), 1);
    chk("unmask_id", int'(irq_id), 0);
    run_to_wait(4'b0000, 4'b1111);
    cycle(4'b0000, 4'b1111, 1'b1);

    // early ack ignored, then re-arm in the ack cycle
    cycle(4'b0100, 4'b1111, 1'b0);
    cycle(4'b0100, 4'b1111, 1'b1);
    while (m_active && m_t < 2 * PW) cycle(4'b0100, 4'b1111, 1'b1);
    chk("early_ack_pend", int'(pending), 4);
    chk("early_ack_busy", int'(busy), 1);
    cycle(4'b0000, 4'b1111, 1'b0);
    cycle(4'b0100, 4'b1111, 1'b1);
    chk("rearm_pend", int'(pending), 4);
    chk("rearm_idle", int'(busy), 0);
    cycle(4'b0100, 4'b1111, 1'b0);
    chk("rearm_irq", int'(IRQ), 1);
    run_to_wait(4'b0000, 4'b1111);
    cycle(4'b0000, 4'b1111, 1'b1);

    // reset mid-pulse with two pending lines held high across release
    cycle(4'b0011, 4'b1111, 1'b0);
    cycle(4'b0011, 4'b1111, 1'b0);
    chk("pre_rst_irq", int'(IRQ), 1);
    chk("pre_rst_pend", int'(pending), 3);
    async_reset(2);
    cycle(4'b0011, 4'b1111, 1'b0);
    chk("post_rst_pend", int'(pending), 3);
    chk("post_rst_noirq", int'(IRQ), 0);
    cycle(4'b0011, 4'b1111, 1'b0);
    chk("post_rst_id", int'(irq_id), 0);
    run_to_wait(4'b0011, 4'b1111);
    cycle(4'b0011, 4'b1111, 1'b1);

    // random traffic
    begin
      logic [N-1:0] iv;
      logic [N-1:0] mv;
      iv = 4'b0011;
      mv = 4'b1111;
      for (int c = 0; c < 3000; c++) begin
        for (int b = 0; b < N; b++) begin
          if ($urandom_range(7) == 0) iv[b] = ~iv[b];
        end
        if ($urandom_range(15) == 0) mv = N'($urandom);
        if ($urandom_range(31) == 0) mv = '1;
        cycle(iv, mv, $urandom_range(2) == 0);
        if ($urandom_range(499) == 0) async_reset(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
